// File: rtl/mem_responder.sv
// mem_responder: windowed word RAM target with req/ready handshake and tri-state read return
// Ports: clock, reset (async, active-low); req/address/rw from the initiator;
//   data is the shared bus, driven only while returning read data;
//   ready is a one-cycle completion pulse; err marks an access outside the window.
module mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int READ_WAIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic [ADDR_W-1:0] address,
  input  logic rw,
  inout  wire  [DATA_W-1:0] data,
  output logic ready,
  output logic err
);
  typedef enum logic [2:0] {IDLE, WAIT, DRIVE, WACK, EACK, TURN} state_t;
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(1) << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT > 0 ? READ_WAIT - 1 : 0);
  state_t state;
  logic [3:0] cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic oe;
  logic hit;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  // Offset in one extra bit: addresses below the base wrap to a huge value, so one compare covers both bounds.
  assign hit = ({1'b0, address} - LO) < SPAN;
  // oe is a reset flop, so the bus is released the moment reset asserts.
  assign data = oe ? mem[idx] : {DATA_W{1'bz}};
  always_ff @(posedge clock)
    if (state == IDLE && req && hit && rw) mem[address[DEPTH_LOG2-1:0]] <= data;
  // ready/err/oe are set on the edge entering DRIVE/WACK/EACK and drop on the next one.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      oe <= 1'b0;
    end else begin
      ready <= 1'b0;
      err <= 1'b0;
      oe <= 1'b0;
      case (state)
        IDLE: if (req) begin
          idx <= address[DEPTH_LOG2-1:0];
          if (!hit) begin
            state <= EACK;
            ready <= 1'b1;
            err <= 1'b1;
          end else if (rw) begin
            state <= WACK;
            ready <= 1'b1;
          end else if (READ_WAIT == 0) begin
            state <= DRIVE;
            ready <= 1'b1;
            oe <= 1'b1;
          end else begin
            state <= WAIT;
            cnt <= WAIT_INIT;
          end
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          state <= DRIVE;
          ready <= 1'b1;
          oe <= 1'b1;
        end
        DRIVE, WACK, EACK: state <= TURN;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (base 0x400 / 2 waits, base 0 / no waits) against a cycle-level model
module tb_mem_responder;
  localparam logic [31:0] BASE [2] = '{32'h400, 32'h0};
  localparam int RWAIT [2] = '{2, 0};
  logic clk, rst_n;
  logic req [2];
  logic rw [2];
  logic doe [2];
  logic rdy [2];
  logic err [2];
  logic [31:0] addr [2];
  logic [31:0] dval [2];
  logic [31:0] busv [2];
  wire [31:0] bus0, bus1;
  assign bus0 = doe[0] ? dval[0] : 'z;
  assign bus1 = doe[1] ? dval[1] : 'z;
  pullup (bus0);
  pullup (bus1);
  assign busv[0] = bus0;
  assign busv[1] = bus1;

  mem_responder #(.BASE_ADDR(32'h400), .READ_WAIT(2)) u0 (
    .clock(clk), .reset(rst_n), .req(req[0]), .address(addr[0]), .rw(rw[0]),
    .data(bus0), .ready(rdy[0]), .err(err[0]));
  mem_responder #(.BASE_ADDR(32'h0), .READ_WAIT(0)) u1 (
    .clock(clk), .reset(rst_n), .req(req[1]), .address(addr[1]), .rw(rw[1]),
    .data(bus1), .ready(rdy[1]), .err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, fails, c;
  int rdy_c [2];
  int idle_c [2];
  int acc_cnt [2];
  bit e_err [2];
  bit e_rd [2];
  logic [31:0] e_val [2];
  logic [31:0] mm [2][1024];

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, c, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns likewise, just after the edge that sampled ready.
  task automatic access(input int k, input logic [31:0] a, input bit w, input logic [31:0] d,
                        input bit scr, input bit keep, output logic [31:0] rd, output bit er,
                        output int lat);
    int base, n;
    bit acc, r;
    base = acc_cnt[k];
    acc = 0;
    n = 0;
    lat = 0;
    rd = '1;
    er = 0;
    req[k] = 1'b1;
    addr[k] = a;
    rw[k] = w;
    dval[k] = d;
    doe[k] = w;
    repeat (64) begin
      @(negedge clk);
      r = rdy[k];
      rd = busv[k];
      er = err[k];
      @(posedge clk);
      #1;
      if (acc) lat++;
      else if (acc_cnt[k] != base) begin
        acc = 1;
        doe[k] = 1'b0;
      end
      if (r) begin
        if (!keep) begin
          req[k] = 1'b0;
          doe[k] = 1'b0;
        end
        return;
      end
      if (acc && scr) begin
        n++;
        addr[k] = $urandom_range(BASE[k] + 1023, BASE[k]);
        rw[k] = $urandom_range(1, 0) == 1;
        dval[k] = $urandom;
        doe[k] = n == 1;
      end
    end
    check("ready_timeout", 32'd0, 32'd1);
    req[k] = 1'b0;
    doe[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, r1, r2, r3;
    checks = 0;
    fails = 0;
    c = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
      rw[k] = 1'b0;
      doe[k] = 1'b0;
      addr[k] = '0;
      dval[k] = '0;
      rdy_c[k] = -10;
      idle_c[k] = 0;
      acc_cnt[k] = 0;
      e_err[k] = 0;
      e_rd[k] = 0;
      e_val[k] = '0;
    end
    #1 rst_n = 1'b0;
    fork
      begin : mon
        logic [31:0] xb;
        bit xr, hit;
        longint a;
        int l, idx;
        forever begin
          @(negedge clk);
          c++;
          for (int k = 0; k < 2; k++) begin
            xr = rst_n && c == rdy_c[k];
            xb = (xr && e_rd[k]) ? e_val[k] : doe[k] ? dval[k] : '1;
            check(k == 0 ? "ready0" : "ready1", 32'(rdy[k]), 32'(xr));
            check(k == 0 ? "err0" : "err1", 32'(err[k]), 32'(xr && e_err[k]));
            check(k == 0 ? "data0" : "data1", busv[k], xb);
            if (!rst_n) begin
              rdy_c[k] = -10;
              idle_c[k] = 0;
            end else if (req[k] && c >= idle_c[k]) begin
              a = longint'(addr[k]);
              hit = a >= longint'(BASE[k]) && a < longint'(BASE[k]) + 1024;
              l = (hit && !rw[k]) ? 1 + RWAIT[k] : 1;
              rdy_c[k] = c + l;
              idle_c[k] = c + l + 2;
              e_err[k] = !hit;
              e_rd[k] = hit && !rw[k];
              if (hit) begin
                idx = int'(a - longint'(BASE[k]));
                if (rw[k]) mm[k][idx] = busv[k];
                e_val[k] = mm[k][idx];
              end
              acc_cnt[k]++;
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_data", bus0, 32'hFFFF_FFFF);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) access(0, 32'h400 + i, 1, $urandom & 32'h7FFF_FFFF, 0, 0, rd, er, lat);
    for (int i = 0; i < 16; i++) access(1, i, 1, $urandom & 32'h7FFF_FFFF, 0, 0, rd, er, lat);
    access(0, 32'h405, 1, 32'hDEAD_BEEF, 0, 0, rd, er, lat);
    check("wr_lat", lat, 32'd1);
    check("wr_err", 32'(er), 32'd0);
    access(0, 32'h405, 0, 0, 0, 0, rd, er, lat);
    check("rd_lat", lat, 32'd3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    access(0, 32'h7FF, 0, 0, 0, 0, rd, er, lat);
    check("last_word_err", 32'(er), 32'd0);
    access(0, 32'h800, 0, 0, 0, 0, rd, er, lat);
    check("above_err", 32'(er), 32'd1);
    check("above_lat", lat, 32'd1);
    check("above_data", rd, 32'hFFFF_FFFF);
    access(0, 32'h3FF, 0, 0, 0, 0, rd, er, lat);
    check("below_err", 32'(er), 32'd1);
    access(0, 32'h800, 1, 32'h0BAD_F00D, 0, 0, rd, er, lat);
    check("wr_miss_err", 32'(er), 32'd1);
    for (int i = 0; i < 1024; i++) access(0, 32'h400 + i, 0, 0, 0, 0, rd, er, lat);
    access(0, 32'h405, 0, 0, 0, 1, rd, er, lat);
    r1 = c;
    access(0, 32'h406, 1, 32'h0000_5A5A, 0, 1, rd, er, lat);
    r2 = c;
    access(0, 32'h406, 0, 0, 0, 0, rd, er, lat);
    r3 = c;
    check("b2b0_gap_wr", r2 - r1, 32'd3);
    check("b2b0_gap_rd", r3 - r2, 32'd5);
    check("b2b0_data", rd, 32'h0000_5A5A);
    access(0, 32'h409, 1, 32'h0000_1234, 0, 0, rd, er, lat);
    access(0, 32'h409, 0, 0, 1, 0, rd, er, lat);
    check("iso_lat", lat, 32'd3);
    check("iso_data", rd, 32'h0000_1234);
    access(1, 32'h3, 1, 32'h0000_00AB, 0, 0, rd, er, lat);
    access(1, 32'h3, 0, 0, 0, 0, rd, er, lat);
    check("rw0_lat", lat, 32'd1);
    check("rw0_data", rd, 32'h0000_00AB);
    access(1, 32'h3, 0, 0, 0, 1, rd, er, lat);
    r1 = c;
    access(1, 32'h4, 1, 32'h0000_0077, 0, 1, rd, er, lat);
    r2 = c;
    access(1, 32'h4, 0, 0, 0, 0, rd, er, lat);
    r3 = c;
    check("b2b1_gap_wr", r2 - r1, 32'd3);
    check("b2b1_gap_rd", r3 - r2, 32'd3);
    check("b2b1_data", rd, 32'h0000_0077);
    idle(2);
    req[0] = 1'b1;
    addr[0] = 32'h405;
    rw[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_ready", 32'(rdy[0]), 32'd1);
    check("pre_rst_data", bus0, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    check("mid_rst_ready", 32'(rdy[0]), 32'd0);
    check("mid_rst_err", 32'(err[0]), 32'd0);
    check("mid_rst_data", bus0, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    access(0, 32'h405, 0, 0, 0, 0, rd, er, lat);
    check("post_rst_lat", lat, 32'd3);
    check("post_rst_data", rd, 32'hDEAD_BEEF);
    access(1, 32'h4, 0, 0, 0, 0, rd, er, lat);
    check("post_rst_data1", rd, 32'h0000_0077);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      bit w, kp, sc;
      a = $urandom_range(32'h900, 32'h300);
      w = $urandom_range(1, 0) == 1;
      kp = i != 1999 && $urandom_range(3, 0) == 0;
      sc = !w && $urandom_range(5, 0) == 0;
      access(0, a, w, $urandom & 32'h7FFF_FFFF, sc, kp, rd, er, lat);
      if (!kp) idle($urandom_range(2, 0));
    end
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
